// File: rtl/qsignmag_conv.sv
// qsignmag_conv
// Streams N-bit two's-complement fixed-point words into the N-bit
// sign-magnitude Q format (bit N-1 = sign, bits N-2:0 = magnitude).
// Two-stage elastic valid/ready pipeline. The single unrepresentable input
// (most-negative word) saturates to full-scale negative and is flagged.
// Saturated deliveries are tallied in a saturating event counter.
module qsignmag_conv #(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [N-1:0]     o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam logic [N-1:0]     MIN_WORD = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]     SAT_WORD = {N{1'b1}};
    localparam logic [N-1:0]     WORD_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Q only places the binary point; the conversion is identical for any Q,
    // but the point must still fall inside the word.
    if (Q < 0 || Q > N - 1) begin : g_bad_q
        $error("qsignmag_conv: Q must lie in 0..N-1");
    end

    logic         s1_valid;
    logic [N-1:0] s1_word;
    logic         s1_neg;
    logic         s1_min;

    logic         s2_valid;
    logic [N-1:0] s2_data;
    logic         s2_ovf;

    logic         s2_adv;
    logic         s1_adv;
    logic         in_xfer;
    logic         out_xfer;

    logic [N-1:0] neg_word;
    logic [N-1:0] conv_data;
    logic         conv_ovf;

    // Handshake: s2 moves when empty or drained; s1 can refill whenever it
    // empties in the same cycle, giving one word per cycle when o_ready is high.
    always_comb begin
        s2_adv   = !s2_valid | o_ready;
        s1_adv   = s1_valid & s2_adv;
        i_ready  = !s1_valid | s2_adv;
        in_xfer  = i_valid & i_ready;
        out_xfer = s2_valid & o_ready;
    end

    // Conversion of the word held in s1. For every negative word other than
    // the minimum, the N-bit negation has a clear MSB, so OR-ing in the sign
    // bit is the same as replacing the MSB with 1.
    always_comb begin
        neg_word  = ~s1_word + WORD_ONE;
        conv_data = s1_word;
        conv_ovf  = 1'b0;
        if (s1_min) begin
            conv_data = SAT_WORD;
            conv_ovf  = 1'b1;
        end else if (s1_neg) begin
            conv_data = neg_word | MIN_WORD;
        end
    end

    // Stage 1: capture the input word together with its sign and min flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_neg   <= 1'b0;
            s1_min   <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_word  <= i_data;
            s1_neg   <= i_data[N-1];
            s1_min   <= (i_data == MIN_WORD);
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register; holds its contents while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= conv_data;
                s2_ovf  <= conv_ovf;
            end
        end
    end

    // Saturating count of delivered saturated beats; a clear overrides a count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (out_xfer && s2_ovf && ovf_count != CNT_MAX) begin
            ovf_count <= ovf_count + CNT_ONE;
        end
    end

    assign o_data  = s2_data;
    assign o_valid = s2_valid;
    assign o_ovf   = s2_ovf;

endmodule
